// File: rtl/logistic_sched_if.sv
// logistic_sched_if
//   Bundle between the chaos-map requesters and the shared logistic-map scheduler.
//   Requesters drive the req_* fields. The scheduler returns per-channel busy, done
//   and result, plus the grant currently using the shared datapath.
//   req_start  [N]     per-channel start strobe
//   req_x0     [17N]   initial x, channel i at [17i+16:17i], 1.0 = 17'h10000
//   req_mu     [18N]   mu, Q2.16, channel i at [18i+17:18i]
//   req_times  [17N]   iteration count
//   ch_busy    [N]     channel iterating
//   ch_done    [N]     one-cycle completion pulse
//   ch_result  [17N]   last final iterate per channel
//   grant_valid        an evaluation is issued this cycle
//   grant_id   [3]     channel receiving this cycle's evaluation
interface logistic_sched_if #(
    parameter int N = 4
);
    logic [N-1:0]      req_start;
    logic [17*N-1:0]   req_x0;
    logic [18*N-1:0]   req_mu;
    logic [17*N-1:0]   req_times;
    logic [N-1:0]      ch_busy;
    logic [N-1:0]      ch_done;
    logic [17*N-1:0]   ch_result;
    logic              grant_valid;
    logic [2:0]        grant_id;

    modport master (
        output req_start, req_x0, req_mu, req_times,
        input  ch_busy, ch_done, ch_result, grant_valid, grant_id
    );

    modport slave (
        input  req_start, req_x0, req_mu, req_times,
        output ch_busy, ch_done, ch_result, grant_valid, grant_id
    );
endinterface

// File: rtl/logistic_sched.sv
// logistic_sched
//   Round-robin scheduler that time-shares one logistic-map datapath,
//   y = mu*x*(1-x), among N iteration channels. At most one evaluation is
//   issued per cycle. Each channel returns its final iterate with a
//   one-cycle done pulse.
//   CLK  clock, rising edge
//   RST  asynchronous active-high reset
//   bus  logistic_sched_if slave modport (requests in; busy/done/result/grant out)
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | channel holds its last result; accepts req_start
//   ST_RUN   | channel competes for the datapath; req_start ignored
module logistic_sched #(
    parameter int N = 4
) (
    input  logic             CLK,
    input  logic             RST,
    logistic_sched_if.slave  bus
);
    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} ch_state_e;

    localparam logic [16:0] ONE = 17'h10000;

    ch_state_e   state_q  [N];
    ch_state_e   state_d  [N];
    logic [16:0] x_q      [N];
    logic [16:0] x_d      [N];
    logic [17:0] mu_q     [N];
    logic [17:0] mu_d     [N];
    logic [16:0] rem_q    [N];
    logic [16:0] rem_d    [N];
    logic [16:0] result_q [N];
    logic [16:0] result_d [N];
    logic [N-1:0] done_q;
    logic [N-1:0] done_d;
    logic [2:0]  rr_ptr_q;
    logic [2:0]  rr_ptr_d;

    logic        grant_valid_c;
    logic [2:0]  grant_c;
    logic [16:0] sel_x;
    logic [17:0] sel_mu;
    logic [16:0] sel_rem;
    logic [33:0] prod_x;
    logic [17:0] t_c;
    logic [35:0] prod_mu;
    logic [16:0] y_c;

    // Arbitration: scan offsets k = 0..N-1 from rr_ptr. Channel j sits at offset k
    // when rr_ptr == (j - k) mod N. Writing the test this way keeps every array
    // index a loop constant.
    always_comb begin
        grant_valid_c = 1'b0;
        grant_c       = '0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!grant_valid_c && state_q[j] == ST_RUN &&
                    int'(rr_ptr_q) == ((j - k + N) % N)) begin
                    grant_valid_c = 1'b1;
                    grant_c       = 3'(j);
                end
            end
        end
    end

    // Shared datapath on the granted channel.
    always_comb begin
        sel_x   = '0;
        sel_mu  = '0;
        sel_rem = '0;
        for (int j = 0; j < N; j++) begin
            if (grant_c == 3'(j)) begin
                sel_x   = x_q[j];
                sel_mu  = mu_q[j];
                sel_rem = rem_q[j];
            end
        end
        prod_x  = sel_x * (ONE - sel_x);
        t_c     = 18'(prod_x >> 16);
        prod_mu = sel_mu * t_c;
        // x <= 1.0 and mu < 4.0 keep y within 17 bits.
        y_c     = 17'(prod_mu >> 16);
    end

    // Next-state: a granted channel advances its iteration. An idle channel
    // may accept a start. These cases are disjoint because only RUN
    // channels are granted.
    always_comb begin
        logic [16:0] x0_c;
        logic [16:0] times_c;
        rr_ptr_d = rr_ptr_q;
        done_d   = '0;
        x0_c     = '0;
        times_c  = '0;
        for (int i = 0; i < N; i++) begin
            state_d[i]  = state_q[i];
            x_d[i]      = x_q[i];
            mu_d[i]     = mu_q[i];
            rem_d[i]    = rem_q[i];
            result_d[i] = result_q[i];
            if (state_q[i] == ST_RUN) begin
                if (grant_valid_c && grant_c == 3'(i)) begin
                    x_d[i]   = y_c;
                    rem_d[i] = sel_rem - 17'd1;
                    if (sel_rem == 17'd1) begin
                        state_d[i]  = ST_IDLE;
                        result_d[i] = y_c;
                        done_d[i]   = 1'b1;
                    end
                end
            end else if (bus.req_start[i]) begin
                x0_c     = bus.req_x0[17*i +: 17];
                times_c  = bus.req_times[17*i +: 17];
                if (x0_c > ONE) begin
                    x0_c = ONE;
                end
                x_d[i]   = x0_c;
                mu_d[i]  = bus.req_mu[18*i +: 18];
                rem_d[i] = times_c;
                if (times_c != 17'd0) begin
                    state_d[i] = ST_RUN;
                end else begin
                    result_d[i] = x0_c;
                    done_d[i]   = 1'b1;
                end
            end
        end
        if (grant_valid_c) begin
            rr_ptr_d = (grant_c == 3'(N - 1)) ? 3'd0 : grant_c + 3'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N; i++) begin
                state_q[i]  <= ST_IDLE;
                x_q[i]      <= '0;
                mu_q[i]     <= '0;
                rem_q[i]    <= '0;
                result_q[i] <= '0;
            end
            done_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                state_q[i]  <= state_d[i];
                x_q[i]      <= x_d[i];
                mu_q[i]     <= mu_d[i];
                rem_q[i]    <= rem_d[i];
                result_q[i] <= result_d[i];
            end
            done_q   <= done_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        bus.ch_busy   = '0;
        bus.ch_result = '0;
        for (int i = 0; i < N; i++) begin
            bus.ch_busy[i]            = (state_q[i] == ST_RUN);
            bus.ch_result[17*i +: 17] = result_q[i];
        end
        bus.ch_done     = done_q;
        bus.grant_valid = grant_valid_c;
        bus.grant_id    = grant_c;
    end
endmodule

// File: tb/tb_logistic_sched.sv
// tb_logistic_sched
//   Directed bench for logistic_sched. An integer-arithmetic reference model is
//   updated on each clock/reset edge. A compare process checks every DUT output
//   against it at each falling edge. Hand-computed literals pin key results.
module tb_logistic_sched;
    localparam int N = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    logistic_sched_if #(.N(N)) bus ();

    logistic_sched #(.N(N)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    int m_run [N];
    int m_x   [N];
    int m_mu  [N];
    int m_rem [N];
    int m_res [N];
    int m_done[N];
    int m_ptr;

    function automatic int map_f(int x, int mu);
        longint t;
        t = (longint'(x) * longint'(65536 - x)) >>> 16;
        return int'(((longint'(mu) * t) >>> 16) & 64'h1FFFF);
    endfunction

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (m_run[(m_ptr + k) % N] != 0) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_run[i] = 0; m_x[i] = 0; m_mu[i] = 0;
            m_rem[i] = 0; m_res[i] = 0; m_done[i] = 0;
        end
        m_ptr = 0;
    endtask

    task automatic model_step();
        int g, y, cx, tm;
        int was_run[N];
        g = pick();
        for (int i = 0; i < N; i++) begin
            was_run[i] = m_run[i];
            m_done[i]  = 0;
        end
        if (g >= 0) begin
            y        = map_f(m_x[g], m_mu[g]);
            m_x[g]   = y;
            m_rem[g] = m_rem[g] - 1;
            m_ptr    = (g + 1) % N;
            if (m_rem[g] == 0) begin
                m_run[g] = 0; m_res[g] = y; m_done[g] = 1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (was_run[i] == 0 && bus.req_start[i]) begin
                cx = int'(bus.req_x0[17*i +: 17]);
                if (cx > 65536) cx = 65536;
                tm = int'(bus.req_times[17*i +: 17]);
                m_x[i] = cx;
                m_mu[i] = int'(bus.req_mu[18*i +: 18]);
                m_rem[i] = tm;
                if (tm != 0) m_run[i] = 1;
                else begin
                    m_res[i] = cx; m_done[i] = 1;
                end
            end
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge CLK or posedge RST);
            if (RST) model_clear();
            else     model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    initial begin
        logic [N-1:0]    eb, ed;
        logic [17*N-1:0] er;
        int g;
        forever begin
            @(negedge CLK);
            eb = '0; ed = '0; er = '0;
            for (int i = 0; i < N; i++) begin
                eb[i] = (m_run[i] != 0);
                ed[i] = (m_done[i] != 0);
                er[17*i +: 17] = 17'(m_res[i]);
            end
            g = pick();
            check("busy",   128'(bus.ch_busy),   128'(eb));
            check("done",   128'(bus.ch_done),   128'(ed));
            check("result", 128'(bus.ch_result), 128'(er));
            check("gvalid", 128'(bus.grant_valid), 128'(g >= 0));
            if (g >= 0) check("gid", 128'(bus.grant_id), 128'(g));
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_req(int ch, int x0, int mu, int t);
        bus.req_start[ch]          = 1'b1;
        bus.req_x0[17*ch +: 17]    = 17'(x0);
        bus.req_mu[18*ch +: 18]    = 18'(mu);
        bus.req_times[17*ch +: 17] = 17'(t);
    endtask

    task automatic edge_clear(output int k);
        @(posedge CLK);
        #1;
        bus.req_start = '0;
        k = cyc;
    endtask

    task automatic wait_done(int ch, int budget, output int at);
        at = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge CLK);
            if (bus.ch_done[ch]) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_chk++;
            $display("FAIL timeout_ch%0d: no done within %0d cycles, expected one", ch, budget);
        end
    endtask

    task automatic realign();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int k, at, cnt;
        int seq[12];
        int dn[3];
        int ns;

        bus.req_start = '0;
        bus.req_x0    = '0;
        bus.req_mu    = '0;
        bus.req_times = '0;

        // Reset state.
        repeat (2) @(posedge CLK);
        #3;
        check("rst_busy",   128'(bus.ch_busy),     128'(0));
        check("rst_result", 128'(bus.ch_result),   128'(0));
        check("rst_gvalid", 128'(bus.grant_valid), 128'(0));
        check("rst_gid",    128'(bus.grant_id),    128'(0));
        RST = 1'b0;
        realign();

        // Two iterations, mu=3: 0x8000 -> 0xC000 -> 0x9000.
        set_req(0, 'h8000, 'h30000, 2);
        edge_clear(k);
        wait_done(0, 10, at);
        check("t1_lat", 128'(at - k), 128'(2));
        check("t1_res", 128'(bus.ch_result[16:0]), 128'('h9000));
        check("t1_busy_at_done", 128'(bus.ch_busy[0]), 128'(0));
        realign();

        // Fixed point at mu=2, busy for exactly 5 cycles.
        set_req(0, 'h8000, 'h20000, 5);
        edge_clear(k);
        cnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge CLK);
            if (bus.ch_busy[0]) cnt++;
        end
        check("t2_busy_cycles", 128'(cnt), 128'(5));
        check("t2_res", 128'(bus.ch_result[16:0]), 128'('h8000));
        realign();

        // Clamp with zero count.
        set_req(2, 'h1FFFF, 'h30000, 0);
        edge_clear(k);
        wait_done(2, 5, at);
        check("t3_lat", 128'(at - k), 128'(0));
        check("t3_res", 128'(bus.ch_result[50:34]), 128'('h10000));
        check("t3_busy", 128'(bus.ch_busy[2]), 128'(0));
        realign();

        // x=1.0 maps to 0 (ch3 first loaded with a nonzero result).
        set_req(3, 'h8000, 'h30000, 0);
        edge_clear(k);
        realign();
        set_req(3, 'h10000, 'h30000, 1);
        edge_clear(k);
        wait_done(3, 5, at);
        check("t4_lat", 128'(at - k), 128'(1));
        check("t4_res", 128'(bus.ch_result[67:51]), 128'(0));
        realign();

        // Start while busy is ignored: 0x8000 -> 0xC000 -> 0x9000 -> 0xBD00.
        set_req(1, 'h8000, 'h30000, 3);
        edge_clear(k);
        set_req(1, 'h4000, 'h20000, 7);
        edge_clear(at);
        wait_done(1, 10, at);
        check("t5_lat", 128'(at - k), 128'(3));
        check("t5_res", 128'(bus.ch_result[33:17]), 128'('hBD00));
        realign();

        // Restart at the completion edge is ignored; another channel's start
        // in that cycle is accepted.
        set_req(0, 'h8000, 'h30000, 1);
        edge_clear(k);
        set_req(0, 'h4000, 'h30000, 1);
        set_req(1, 'h8000, 'h20000, 2);
        edge_clear(at);
        @(negedge CLK);
        check("t6_done0", 128'(bus.ch_done[0]), 128'(1));
        check("t6_res0",  128'(bus.ch_result[16:0]), 128'('hC000));
        check("t6_busy0", 128'(bus.ch_busy[0]), 128'(0));
        check("t6_busy1", 128'(bus.ch_busy[1]), 128'(1));
        wait_done(1, 10, at);
        check("t6_lat1", 128'(at - k), 128'(3));
        check("t6_res1", 128'(bus.ch_result[33:17]), 128'('h8000));
        realign();

        // Asynchronous reset with three channels running.
        set_req(0, 'h8000, 'h30000, 20);
        set_req(1, 'h8000, 'h30000, 20);
        set_req(2, 'h8000, 'h30000, 20);
        edge_clear(k);
        repeat (4) @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        check("t7_busy",   128'(bus.ch_busy),     128'(0));
        check("t7_done",   128'(bus.ch_done),     128'(0));
        check("t7_result", 128'(bus.ch_result),   128'(0));
        check("t7_gvalid", 128'(bus.grant_valid), 128'(0));
        repeat (2) @(posedge CLK);
        #3;
        RST = 1'b0;
        realign();

        // Fairness from rr_ptr=0.
        set_req(0, 'h8000, 'h20000, 4);
        set_req(1, 'h8000, 'h20000, 4);
        set_req(2, 'h8000, 'h20000, 4);
        edge_clear(k);
        ns = 0;
        dn[0] = -1; dn[1] = -1; dn[2] = -1;
        for (int n = 0; n < 15; n++) begin
            @(negedge CLK);
            if (bus.grant_valid && ns < 12) begin
                seq[ns] = int'(bus.grant_id);
                ns++;
            end
            for (int c = 0; c < 3; c++) begin
                if (bus.ch_done[c]) dn[c] = cyc - k;
            end
        end
        check("t8_ngrants", 128'(ns), 128'(12));
        for (int n = 0; n < 12; n++) begin
            if (n < ns) check($sformatf("t8_seq%0d", n), 128'(seq[n]), 128'(n % 3));
        end
        check("t8_done0", 128'(dn[0]), 128'(10));
        check("t8_done1", 128'(dn[1]), 128'(11));
        check("t8_done2", 128'(dn[2]), 128'(12));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
